// File: rtl/multicycle_addsub.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Results load into out/co/ovf on the edge entering DONE and hold until the next one.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N  = WIDTH / CW;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CW) != 0) begin : g_bad_chunk
      $error("multicycle_addsub: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [KW-1:0]    k;

  logic [CW:0]      csum;
  logic [WIDTH-1:0] acc_nx;
  logic             msb_ovf;

  // Operands shift right each cycle so the active chunk is always the low one;
  // chunk sums shift in from the top so acc is aligned after the last chunk.
  always_comb begin
    csum = {1'b0, a[CW-1:0]}
         + {1'b0, b[CW-1:0]}
         + {{CW{1'b0}}, carry};
    acc_nx = (acc >> CW)
           | (WIDTH'(csum[CW-1:0]) << (WIDTH - CW));
    msb_ovf = (a[CW-1] == b[CW-1])
           && (csum[CW-1] != a[CW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      carry <= 1'b0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a     <= in1;
            b     <= sub ? ~in2 : in2;
            carry <= cin ^ sub;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a     <= a >> CW;
          b     <= b >> CW;
          acc   <= acc_nx;
          carry <= csum[CW];
          k     <= k + 1'b1;
          if (k == KLAST) begin
            out   <= acc_nx;
            co    <= csum[CW];
            ovf   <= msb_ovf;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed bench for multicycle_addsub (WIDTH=16, CHUNK=4).
// Outputs are sampled on the falling edge; inputs change there too.
module tb_multicycle_addsub;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         co;
  logic         ovf;

  int ncmp = 0;
  int nbad = 0;
  logic [W-1:0] prev_out;

  always #5 clk = ~clk;

  multicycle_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .in1  (in1),
    .in2  (in2),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .out  (out),
    .co   (co),
    .ovf  (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of the
  // DONE cycle so the next call can issue a back-to-back start.
  task automatic op(input string tag,
                    input logic s,
                    input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic ci,
                    input logic [W-1:0] eo,
                    input logic eco,
                    input logic eov);
    start = 1'b1;
    sub   = s;
    in1   = a;
    in2   = b;
    cin   = ci;
    @(negedge clk);
    start = 1'b0;
    sub   = 1'($urandom);
    in1   = W'($urandom);
    in2   = W'($urandom);
    cin   = 1'($urandom);
    for (int i = 1; i <= N; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(out), 32'(prev_out));
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_co"}, 32'(co), 32'(eco));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
    prev_out = eo;
  endtask

  task automatic quiet(input string tag,
                       input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_nobusy"}, 32'(busy), 32'd0);
      chk({tag, "_held"}, 32'(out), 32'(prev_out));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    in1   = 16'h1111;
    in2   = 16'h2222;
    cin   = 1'b0;
    prev_out = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // start on the very first cycle after reset
    rst = 1'b0;
    op("add", 1'b0, 16'h1234, 16'h0FCD, 1'b0,
       16'h2201, 1'b0, 1'b0);
    quiet("after_add", 1);

    op("carry", 1'b0, 16'hFFFF, 16'h0000, 1'b1,
       16'h0000, 1'b1, 1'b0);
    quiet("after_carry", 1);

    op("sovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0,
       16'h8000, 1'b0, 1'b1);
    quiet("after_sovf", 1);

    op("sub", 1'b1, 16'h0005, 16'h0007, 1'b0,
       16'hFFFE, 1'b0, 1'b0);
    op("b2b", 1'b1, 16'h8000, 16'h0001, 1'b0,
       16'h7FFF, 1'b1, 1'b1);
    op("b2b2", 1'b1, 16'h0010, 16'h0003, 1'b1,
       16'h000C, 1'b1, 1'b0);
    op("negov", 1'b0, 16'h8000, 16'h8000, 1'b0,
       16'h0000, 1'b1, 1'b1);
    quiet("after_b2b", 2);

    // start while busy is ignored
    start = 1'b1;
    sub   = 1'b0;
    in1   = 16'h0001;
    in2   = 16'h0001;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("bs_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("bs_busy2", 32'(busy), 32'd1);
    start = 1'b1;
    in1   = 16'hAAAA;
    in2   = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    chk("bs_busy3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("bs_busy4", 32'(busy), 32'd1);
    @(negedge clk);
    chk("bs_done", 32'(done), 32'd1);
    chk("bs_out", 32'(out), 32'h0002);
    chk("bs_co", 32'(co), 32'd0);
    prev_out = 16'h0002;
    quiet("bs_after", 6);

    // reset in busy cycle 2 aborts the operation
    start = 1'b1;
    in1   = 16'h1111;
    in2   = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    chk("ra_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ra_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_out", 32'(out), 32'd0);
    chk("ra_co", 32'(co), 32'd0);
    chk("ra_ovf", 32'(ovf), 32'd0);
    prev_out = '0;
    quiet("ra_nodone", N + 2);

    op("post_rst", 1'b0, 16'h1111, 16'h2222, 1'b1,
       16'h3334, 1'b0, 1'b0);
    quiet("end", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
